// File: rtl/snow64_clz_seq_pkg.sv
// Shared types and helpers for the CLZ sequencer: size codes, FSM states,
// the captured request, and the padded 32-bit CLZ input builder.
package snow64_clz_seq_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int CNT_WIDTH  = 7;

  typedef enum logic [1:0] {
    SZ_8  = 2'd0,
    SZ_16 = 2'd1,
    SZ_32 = 2'd2,
    SZ_64 = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PASS_HI = 2'd1,
    ST_PASS_LO = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] operand;
    size_e                 size;
  } req_t;

  // Ones-padding below a narrow operand caps the count at its width.
  function automatic logic [31:0] clz_pad(input logic [DATA_WIDTH-1:0] op,
                                          input size_e sz);
    case (sz)
      SZ_8:    return {op[7:0], 24'hFF_FFFF};
      SZ_16:   return {op[15:0], 16'hFFFF};
      SZ_32:   return op[31:0];
      default: return op[63:32];
    endcase
  endfunction

endpackage

// File: rtl/Snow64CountLeadingZeros32.sv
// 32-bit count-leading-zeros; a zero input yields 32.
module Snow64CountLeadingZeros32 (
  input  logic [31:0] value,
  output logic [5:0]  count
);

  // Scan upward so the highest set bit writes last and wins.
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) count = 6'(31 - i);
    end
  end

endmodule

// File: rtl/snow64_clz_sequencer.sv
// Round-robin shared CLZ service: two requesters, one 32-bit CLZ unit,
// 64-bit operands with a zero upper half take a second pass.
module snow64_clz_sequencer
  import snow64_clz_seq_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand,
  input  logic [NUM_REQ*2-1:0]          req_size,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CNT_WIDTH-1:0]          out_count,
  output logic                          out_id
);

  state_e                state;
  req_t                  req_q;
  logic                  last_grant;
  logic                  grant;
  logic                  accept;
  logic [31:0]           clz_in;
  logic [5:0]            clz_cnt;
  logic                  hi_zero;
  req_t                  sel_req;

  // Arbitration: a lone requester wins; on contention, alternate.
  always_comb begin
    case (req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  assign accept    = (state == ST_IDLE) && (|req_valid);
  assign req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

  assign sel_req.operand = grant ? req_operand[2*DATA_WIDTH-1:DATA_WIDTH]
                                 : req_operand[DATA_WIDTH-1:0];
  assign sel_req.size    = size_e'(grant ? req_size[3:2] : req_size[1:0]);

  assign clz_in  = (state == ST_PASS_LO) ? req_q.operand[31:0]
                                         : clz_pad(req_q.operand, req_q.size);
  assign hi_zero = (req_q.size == SZ_64) && (req_q.operand[63:32] == 32'd0);

  Snow64CountLeadingZeros32 u_clz (
    .value (clz_in),
    .count (clz_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      last_grant <= 1'b1;
      out_valid  <= 1'b0;
      out_count  <= '0;
      out_id     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_q      <= sel_req;
            last_grant <= grant;
            out_id     <= grant;
            state      <= ST_PASS_HI;
          end
        end
        ST_PASS_HI: begin
          if (hi_zero) begin
            state <= ST_PASS_LO;
          end else begin
            out_count <= {1'b0, clz_cnt};
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_PASS_LO: begin
          // Upper half was all zero, so its 32 zeros precede the low-half count.
          out_count <= 7'd32 + {1'b0, clz_cnt};
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snow64_clz_sequencer.sv
// Directed and randomized checks of the CLZ sequencer against a bit-scan
// reference model with its own round-robin bookkeeping.
module tb_snow64_clz_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready;
  logic [127:0] req_operand = '0;
  logic [3:0]   req_size = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [6:0]   out_count;
  logic         out_id;

  int vectors = 0;
  int miscompares = 0;
  int model_last = 1;

  always #5 clk = ~clk;

  snow64_clz_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_operand (req_operand),
    .req_size    (req_size),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_count   (out_count),
    .out_id      (out_id)
  );

  function automatic int ref_clz(input logic [63:0] op, input logic [1:0] sz);
    int w = 8 << sz;
    int n = 0;
    for (int i = w - 1; i >= 0; i--) begin
      if (op[i]) break;
      n++;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation: present requests, check grant, latency, result, handshake.
  task automatic run_op(input bit v0, input bit v1,
                        input logic [63:0] o0, input logic [63:0] o1,
                        input logic [1:0] s0, input logic [1:0] s1,
                        input int hold, input bit keep);
    int g, lat, cyc, exp_cnt;
    logic [63:0] op;
    logic [1:0] sz;
    g = (v0 && v1) ? 1 - model_last : (v1 ? 1 : 0);
    op = g ? o1 : o0;
    sz = g ? s1 : s0;
    exp_cnt = ref_clz(op, sz);
    lat = (sz == 2'd3 && op[63:32] == 32'd0) ? 3 : 2;
    req_valid   = {v1, v0};
    req_operand = {o1, o0};
    req_size    = {s1, s0};
    #1;
    chk("grant_ready", 64'(req_ready), g ? 64'h2 : 64'h1);
    @(posedge clk);
    model_last = g;
    cyc = 0;
    while (!out_valid && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (!keep) req_valid = '0;
      if (!out_valid) chk("busy_ready", 64'(req_ready), 64'h0);
    end
    chk("latency", 64'(cyc), 64'(lat));
    chk("count", 64'(out_count), 64'(exp_cnt));
    chk("id", 64'(out_id), 64'(g));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'h1);
      chk("hold_count", 64'(out_count), 64'(exp_cnt));
      chk("hold_id", 64'(out_id), 64'(g));
      chk("hold_ready", 64'(req_ready), 64'h0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", 64'(out_valid), 64'h0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_count", 64'(out_count), 64'h0);
    chk("rst_id", 64'(out_id), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(1, 0, 64'h10, 64'h0, 2'd0, 2'd0, 0, 0);
    run_op(0, 1, 64'h0, 64'h1_0000, 2'd0, 2'd3, 0, 0);
    run_op(1, 0, 64'h0, 64'h0, 2'd0, 2'd0, 0, 0);
    run_op(0, 1, 64'h0, 64'h0, 2'd0, 2'd1, 0, 0);
    run_op(1, 0, 64'h0, 64'h0, 2'd2, 2'd0, 0, 0);
    run_op(0, 1, 64'h0, 64'h0, 2'd0, 2'd3, 0, 0);
    run_op(1, 0, 64'h8000_0000_0000_0000, 64'h0, 2'd3, 2'd0, 0, 0);
    run_op(1, 0, 64'hFFFF_FF00_0000_0001, 64'h0, 2'd0, 2'd0, 0, 0);

    // Contention with both held: grants alternate
    for (int k = 0; k < 4; k++)
      run_op(1, 1, 64'h0000_00F0_0000_0000, 64'h0000_0000_0000_0F00, 2'd3, 2'd3, 0, 1);

    // Backpressure
    run_op(1, 1, 64'h0123_4567, 64'h00FF_0000_0000_0000, 2'd2, 2'd3, 5, 0);

    // Reset while in PASS_LO
    req_valid = 2'b10; req_operand = {64'hFF, 64'h0}; req_size = 4'b1100;
    #1 chk("pre_rst_ready", 64'(req_ready), 64'h2);
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    chk("pass_lo_valid", 64'(out_valid), 64'h0);
    rst_n = 1'b0; req_valid = 2'b11;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'h1);
    chk("midrst_valid", 64'(out_valid), 64'h0);
    req_valid = '0;
    @(negedge clk); rst_n = 1'b1; model_last = 1;
    repeat (3) begin
      @(negedge clk);
      chk("dropped_result", 64'(out_valid), 64'h0);
    end
    run_op(1, 1, 64'h0000_0000_0000_3000, 64'h1, 2'd1, 2'd0, 0, 0);

    // Reset while holding a valid result drops out_valid asynchronously
    req_valid = 2'b01; req_operand = {64'h0, 64'h4}; req_size = 4'b0000;
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    chk("done_valid", 64'(out_valid), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_drop", 64'(out_valid), 64'h0);
    chk("async_count", 64'(out_count), 64'h0);
    @(negedge clk); rst_n = 1'b1; model_last = 1;
    @(negedge clk);

    // Randomized traffic
    for (int r = 0; r < 40; r++) begin
      logic [1:0] vv;
      logic [63:0] a, b;
      vv = 2'($urandom_range(1, 3));
      a = {$urandom, $urandom} >> $urandom_range(0, 63);
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) a = '0;
      run_op(vv[0], vv[1], a, b, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
